// File: rtl/conv_filter_scheduler.sv
// conv_filter_scheduler: runs NUM_FILTERS filter passes per KxK window through a
// pipelined convolution datapath, then tags and checks the returning results.
module conv_filter_scheduler #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_FILTERS  = 4,
    parameter int CONV_LATENCY = 4,
    parameter int FW           = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      win_valid,
    output logic                                      win_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] win_data,
    output logic                                      wmem_rd,
    output logic [FW-1:0]                             wmem_addr,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wmem_weights,
    input  logic [DATA_WIDTH-1:0]                     wmem_bias,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] conv_data,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] conv_weights,
    output logic [DATA_WIDTH-1:0]                     conv_bias,
    output logic                                      conv_valid,
    input  logic [DATA_WIDTH-1:0]                     conv_result,
    input  logic                                      conv_result_valid,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic                                      out_valid,
    output logic [FW-1:0]                             out_filter,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      protocol_error
);

    localparam int WIN_W  = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE;
    localparam int DEPTH  = CONV_LATENCY + 1;
    localparam int MASK_W = $clog2(CONV_LATENCY + 2);
    localparam logic [FW-1:0]     LAST_FILT = FW'(NUM_FILTERS - 1);
    localparam logic [MASK_W-1:0] MASK_MAX  = MASK_W'(CONV_LATENCY + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, next_state;
    logic [FW-1:0]     filt_cnt;
    logic [WIN_W-1:0]  win_reg;
    logic              accept;
    logic              is_last;
    logic [DEPTH-1:0]  tag_valid;
    logic [DEPTH-1:0]  tag_last;
    logic [FW-1:0]     tag_filt [DEPTH];
    logic [MASK_W-1:0] mask_cnt;
    logic              masked;

    assign is_last      = (filt_cnt == LAST_FILT);
    assign accept       = win_valid && win_ready;
    assign masked       = (mask_cnt != MASK_MAX);
    assign conv_weights = wmem_weights;
    assign conv_bias    = wmem_bias;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (is_last && !accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The last-filter cycle doubles as an accept slot so windows stream without a bubble.
    always_comb begin
        win_ready = (state == IDLE) || ((state == RUN) && is_last);
        wmem_rd   = (state == RUN);
        wmem_addr = filt_cnt;
        busy      = (state == RUN) || (|tag_valid) || out_valid;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt <= '0;
            win_reg  <= '0;
        end else if (accept) begin
            filt_cnt <= '0;
            win_reg  <= win_data;
        end else if (wmem_rd) begin
            filt_cnt <= is_last ? '0 : filt_cnt + 1'b1;
        end
    end

    // Delayed one cycle so the window lines up with the memory's read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conv_valid <= 1'b0;
            conv_data  <= '0;
        end else begin
            conv_valid <= wmem_rd;
            if (wmem_rd) conv_data <= win_reg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
            for (int i = 0; i < DEPTH; i++) tag_filt[i] <= '0;
        end else begin
            tag_valid   <= {tag_valid[DEPTH-2:0], wmem_rd};
            tag_last    <= {tag_last[DEPTH-2:0], is_last};
            tag_filt[0] <= filt_cnt;
            for (int i = 1; i < DEPTH; i++) tag_filt[i] <= tag_filt[i-1];
        end
    end

    // The datapath has no reset, so its stale valids are ignored for a while after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    mask_cnt <= '0;
        else if (masked) mask_cnt <= mask_cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_filter     <= '0;
            out_last       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            out_valid  <= conv_result_valid && tag_valid[CONV_LATENCY];
            out_data   <= conv_result;
            out_filter <= tag_filt[CONV_LATENCY];
            out_last   <= tag_last[CONV_LATENCY];
            if (!masked && (conv_result_valid != tag_valid[CONV_LATENCY]))
                protocol_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// tb_conv_filter_scheduler: directed bench with a weight-memory model and a
// fixed-latency Q2.14 datapath model around conv_filter_scheduler.
module tb_conv_filter_scheduler;

    localparam int K   = 3;
    localparam int DW  = 16;
    localparam int NF  = 4;
    localparam int LAT = 4;
    localparam int FW  = 2;
    localparam int WW  = DW * K * K;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          win_valid = 1'b0;
    logic          win_ready;
    logic [WW-1:0] win_data = '0;
    logic          wmem_rd;
    logic [FW-1:0] wmem_addr;
    logic [WW-1:0] wmem_weights = '0;
    logic [DW-1:0] wmem_bias = '0;
    logic [WW-1:0] conv_data, conv_weights;
    logic [DW-1:0] conv_bias;
    logic          conv_valid;
    logic [DW-1:0] conv_result;
    logic          conv_result_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [FW-1:0] out_filter;
    logic          out_last, busy, protocol_error;

    conv_filter_scheduler #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .NUM_FILTERS(NF), .CONV_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .wmem_rd(wmem_rd), .wmem_addr(wmem_addr),
        .wmem_weights(wmem_weights), .wmem_bias(wmem_bias),
        .conv_data(conv_data), .conv_weights(conv_weights), .conv_bias(conv_bias),
        .conv_valid(conv_valid), .conv_result(conv_result),
        .conv_result_valid(conv_result_valid),
        .out_data(out_data), .out_valid(out_valid), .out_filter(out_filter),
        .out_last(out_last), .busy(busy), .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [FW-1:0] filt;
        logic          last;
    } res_t;

    res_t log_q[$];
    res_t exp_q[$];
    res_t mon_r;
    int   e = 0;
    int   t0 = 0;
    int   cv_count = 0, cv_first = 0, cv_last = 0;
    int   vec_count = 0, err_count = 0;
    logic bias_on = 1'b0;
    logic inject = 1'b0;
    logic [LAT-1:0] dp_v = '0;
    logic [DW-1:0]  dp_d [LAT];

    function automatic logic [DW-1:0] memWeight(input logic [FW-1:0] a);
        return DW'(a) << 10;
    endfunction

    function automatic logic [DW-1:0] dpCompute(input logic [WW-1:0] d, input logic [WW-1:0] w,
                                                input logic [DW-1:0] b);
        logic signed [39:0] acc;
        logic signed [31:0] x, y, p;
        acc = '0;
        for (int k = 0; k < K*K; k++) begin
            x   = $signed(d[k*DW +: DW]);
            y   = $signed(w[k*DW +: DW]);
            p   = x * y;
            acc = acc + 40'(p);
        end
        return DW'(acc >>> 14) + b;
    endfunction

    // Weight memory: filter f holds all weights f*0x0400, bias f when bias_on.
    always @(posedge clock) begin
        if (wmem_rd === 1'b1) begin
            wmem_weights <= {(K*K){memWeight(wmem_addr)}};
            wmem_bias    <= bias_on ? DW'(wmem_addr) : '0;
        end
    end

    // Datapath model without reset, so it keeps flushing through a DUT reset.
    always @(posedge clock) begin
        dp_v    <= {dp_v[LAT-2:0], conv_valid === 1'b1};
        dp_d[0] <= dpCompute(conv_data, conv_weights, conv_bias);
        for (int i = 1; i < LAT; i++) dp_d[i] <= dp_d[i-1];
    end

    assign conv_result_valid = dp_v[LAT-1] | inject;
    assign conv_result       = dp_d[LAT-1];

    always @(posedge clock) e <= e + 1;

    always @(posedge clock) begin
        #1;
        if (out_valid === 1'b1) begin
            mon_r.cyc  = e;
            mon_r.data = out_data;
            mon_r.filt = out_filter;
            mon_r.last = out_last;
            log_q.push_back(mon_r);
        end
        if (conv_valid === 1'b1) begin
            if (cv_count == 0) cv_first = e;
            cv_last = e;
            cv_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic gotoCycle(input int c);
        while (e - t0 + 1 < c) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] elem);
        win_data  = {(K*K){elem}};
        win_valid = 1'b1;
    endtask

    task automatic startWindow(input logic [DW-1:0] elem);
        applyStimulus(elem);
        t0 = e + 1;
        @(negedge clock);
        win_valid = 1'b0;
    endtask

    task automatic expectResult(input int c, input logic [DW-1:0] d, input int f, input logic l);
        res_t r;
        r.cyc  = c;
        r.data = d;
        r.filt = FW'(f);
        r.last = l;
        exp_q.push_back(r);
    endtask

    task automatic checkLog(input string tag);
        checkOutput($sformatf("%s count", tag), log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checkOutput($sformatf("%s[%0d] cycle", tag, i), log_q[i].cyc - t0 + 1, exp_q[i].cyc);
            checkOutput($sformatf("%s[%0d] data", tag, i), log_q[i].data, exp_q[i].data);
            checkOutput($sformatf("%s[%0d] filter", tag, i), log_q[i].filt, exp_q[i].filt);
            checkOutput($sformatf("%s[%0d] last", tag, i), log_q[i].last, exp_q[i].last);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst wmem_rd", wmem_rd, 0);
        checkOutput("rst conv_valid", conv_valid, 0);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_last", out_last, 0);
        checkOutput("rst out_filter", out_filter, 0);
        checkOutput("rst out_data", out_data, 0);
        checkOutput("rst protocol_error", protocol_error, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst win_ready", win_ready, 1);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);

        $display("[TB] single window");
        startWindow(16'h4000);
        gotoCycle(2);
        checkOutput("s1 win_ready", win_ready, 0);
        checkOutput("s1 wmem_rd", wmem_rd, 1);
        gotoCycle(10);
        checkOutput("s1 busy c10", busy, 1);
        gotoCycle(11);
        checkOutput("s1 busy c11", busy, 0);
        checkOutput("s1 protocol_error", protocol_error, 0);
        gotoCycle(14);
        expectResult(7,  16'h0000, 0, 0);
        expectResult(8,  16'h2400, 1, 0);
        expectResult(9,  16'h4800, 2, 0);
        expectResult(10, 16'h6C00, 3, 1);
        checkLog("s1");

        $display("[TB] back-to-back windows");
        cv_count = 0;
        startWindow(16'h4000);
        gotoCycle(2);
        applyStimulus(16'h2000);
        checkOutput("s2 win_ready c2", win_ready, 0);
        gotoCycle(3);
        checkOutput("s2 win_ready c3", win_ready, 0);
        gotoCycle(4);
        checkOutput("s2 win_ready c4", win_ready, 1);
        gotoCycle(5);
        win_valid = 1'b0;
        gotoCycle(18);
        checkOutput("s2 conv_valid count", cv_count, 8);
        checkOutput("s2 conv_valid first", cv_first - t0 + 1, 2);
        checkOutput("s2 conv_valid last", cv_last - t0 + 1, 9);
        checkOutput("s2 busy end", busy, 0);
        for (int i = 0; i < 4; i++) expectResult(7 + i, DW'(i * 'h2400), i, i == 3);
        for (int i = 0; i < 4; i++) expectResult(11 + i, DW'(i * 'h1200), i, i == 3);
        checkLog("s2");

        $display("[TB] upstream gap");
        startWindow(16'h4000);
        gotoCycle(5);
        checkOutput("s3 win_ready c5", win_ready, 1);
        checkOutput("s3 wmem_rd c5", wmem_rd, 0);
        gotoCycle(8);
        applyStimulus(16'h2000);
        gotoCycle(9);
        win_valid = 1'b0;
        gotoCycle(20);
        for (int i = 0; i < 4; i++) expectResult(7 + i, DW'(i * 'h2400), i, i == 3);
        for (int i = 0; i < 4; i++) expectResult(15 + i, DW'(i * 'h1200), i, i == 3);
        checkLog("s3");

        $display("[TB] reset mid-frame");
        startWindow(16'h4000);
        gotoCycle(5);
        reset_n = 1'b0;
        gotoCycle(6);
        checkOutput("s5 out_valid in reset", out_valid, 0);
        gotoCycle(7);
        reset_n = 1'b1;
        gotoCycle(16);
        checkLog("s5 flush");
        checkOutput("s5 protocol_error", protocol_error, 0);
        checkOutput("s5 busy", busy, 0);
        bias_on = 1'b1;
        startWindow(16'h4000);
        gotoCycle(14);
        expectResult(7,  16'h0000, 0, 0);
        expectResult(8,  16'h2401, 1, 0);
        expectResult(9,  16'h4802, 2, 0);
        expectResult(10, 16'h6C03, 3, 1);
        checkLog("s5 next");
        bias_on = 1'b0;

        $display("[TB] misalignment");
        startWindow(16'h4000);
        gotoCycle(5);
        checkOutput("s4 perr before", protocol_error, 0);
        inject = 1'b1;
        gotoCycle(6);
        inject = 1'b0;
        checkOutput("s4 perr set", protocol_error, 1);
        gotoCycle(14);
        expectResult(7,  16'h0000, 0, 0);
        expectResult(8,  16'h2400, 1, 0);
        expectResult(9,  16'h4800, 2, 0);
        expectResult(10, 16'h6C00, 3, 1);
        checkLog("s4");
        startWindow(16'h2000);
        gotoCycle(12);
        checkOutput("s4 perr sticky", protocol_error, 1);
        log_q.delete();
        reset_n = 1'b0;
        @(negedge clock);
        checkOutput("s4 perr cleared", protocol_error, 0);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
